// File: rtl/wb_host_pkg.sv
// wb_host_pkg: shared state type, bus widths and default error word for the Wishbone host master
package wb_host_pkg;
    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;
    localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr: 16-bit saturating wait counter flagging the last allowed no-ack cycle
module wb_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] count_q, count_d;
    always_comb count_d = clear ? '0 : (enable && count_q != '1) ? count_q + 16'd1 : count_q;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) count_q <= '0;
        else count_q <= count_d;
    assign expired = enable && count_q == LAST;
endmodule

// File: rtl/wb_host_master.sv
// wb_host_master: single-outstanding Wishbone classic initiator behind valid/ready command and response channels
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [WB_DW-1:0]  ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [WB_AW-1:0] cmd_adr,
    input  logic [WB_DW-1:0] cmd_dat,
    input  logic [WB_SW-1:0] cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WB_DW-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    output logic [WB_SW-1:0] wbm_sel_o,
    input  logic [WB_DW-1:0] wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy
);
    state_t           state_q, state_d;
    logic             cyc_q, cyc_d, we_q, we_d, err_q, err_d;
    logic [WB_AW-1:0] adr_q, adr_d;
    logic [WB_DW-1:0] dat_q, dat_d, rdat_q, rdat_d;
    logic [WB_SW-1:0] sel_q, sel_d;
    logic             accept, expired;

    assign accept = state_q == IDLE && cmd_valid;

    wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctr (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .clear   (accept),
        .enable  (state_q == BUS && !wbm_ack_i),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = BUS;
                cyc_d   = 1'b1;
                we_d    = cmd_we;
                adr_d   = cmd_adr;
                dat_d   = cmd_dat;
                sel_d   = cmd_sel;
            end
            // ack is checked first so a last-cycle ack beats the timeout
            BUS: if (wbm_ack_i) begin
                state_d = RESP;
                cyc_d   = 1'b0;
                rdat_d  = we_q ? '0 : wbm_dat_i;
                err_d   = 1'b0;
            end else if (expired) begin
                state_d = RESP;
                cyc_d   = 1'b0;
                rdat_d  = we_q ? '0 : ERR_DATA;
                err_d   = 1'b1;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end

    assign cmd_ready = state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign busy      = state_q != IDLE;
    assign rsp_dat   = rdat_q;
    assign rsp_err   = err_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
endmodule

// File: tb/tb_wb_host_master.sv
// tb_wb_host_master: directed vector table plus hand sequences for backpressure and mid-cycle reset
module tb_wb_host_master;
    logic        wb_clk_i = 1'b0, wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        cmd_ready, rsp_valid, rsp_err, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, busy;
    logic [31:0] rsp_dat, wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;

    wb_host_master #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // slave model: acks in stb cycle slv_wait (0-based), never when negative
    int          slv_wait = -1;
    logic [31:0] slv_rdata = '0;
    int          ack_idx = 0;
    always @(posedge wb_clk_i) ack_idx <= wbm_stb_o ? ack_idx + 1 : 0;
    assign wbm_ack_i = wbm_stb_o && slv_wait >= 0 && ack_idx == slv_wait;
    assign wbm_dat_i = slv_rdata;

    // bus monitor: length of last stb burst, first-cycle values, and any change while stb high
    int          stb_run = 0;
    logic        prev_stb = 1'b0, moved = 1'b0, cap_we = 1'b0;
    logic [31:0] cap_adr = '0, cap_dat = '0;
    logic [3:0]  cap_sel = '0;
    always @(negedge wb_clk_i) begin
        if (wbm_stb_o && !prev_stb) begin
            stb_run = 1; moved = wbm_cyc_o !== 1'b1;
            cap_adr = wbm_adr_o; cap_dat = wbm_dat_o; cap_sel = wbm_sel_o; cap_we = wbm_we_o;
        end else if (wbm_stb_o) begin
            stb_run++;
            if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== cap_adr || wbm_dat_o !== cap_dat ||
                wbm_sel_o !== cap_sel || wbm_we_o !== cap_we) moved = 1'b1;
        end
        prev_stb = wbm_stb_o;
    end

    int n_vec = 0, n_bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        int          wait_st;
        logic [31:0] rdata;
        int          stb_len;
        logic [31:0] rdat;
        logic        err;
        int          lat;
    } vec_t;
    vec_t tbl[8];

    task automatic run_vec(input vec_t v, input string nm);
        int k, lat;
        slv_wait = v.wait_st; slv_rdata = v.rdata;
        cmd_valid = 1'b1; cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_sel = v.sel;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 20) begin @(negedge wb_clk_i); k++; end
        chk({nm, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 300) begin @(negedge wb_clk_i); lat++; end
        chk({nm, " latency"}, 32'(lat), 32'(v.lat));
        chk({nm, " rsp_dat"}, rsp_dat, v.rdat);
        chk({nm, " rsp_err"}, 32'(rsp_err), 32'(v.err));
        chk({nm, " stb_len"}, 32'(stb_run), 32'(v.stb_len));
        chk({nm, " bus_adr"}, cap_adr, v.adr);
        chk({nm, " bus_we_sel"}, {27'd0, cap_we, cap_sel}, {27'd0, v.we, v.sel});
        if (v.we) chk({nm, " bus_dat"}, cap_dat, v.dat);
        chk({nm, " bus_stable"}, 32'(moved), 32'd0);
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        chk({nm, " after_hs"}, {29'd0, rsp_valid, cmd_ready, busy}, 32'b010);
    endtask

    initial begin
        int k;
        //            we    adr            dat            sel    W   rdata          stb rdat           err lat
        tbl[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF,  0, 32'hFFFF_FFFF, 1, 32'h0,          1'b0, 2};
        tbl[1] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF,  3, 32'hCAFE_F00D, 4, 32'hCAFE_F00D, 1'b0, 5};
        tbl[2] = '{1'b0, 32'h3000_0010, 32'h0,         4'hF, -1, 32'h1111_1111, 8, 32'hDEAD_BEEF, 1'b1, 9};
        tbl[3] = '{1'b1, 32'h3000_0014, 32'h1111_2222, 4'h3, -1, 32'hFFFF_FFFF, 8, 32'h0,          1'b1, 9};
        tbl[4] = '{1'b0, 32'h3000_0018, 32'h0,         4'hF,  7, 32'h1234_5678, 8, 32'h1234_5678, 1'b0, 9};
        tbl[5] = '{1'b1, 32'h3000_001C, 32'h0F0F_F0F0, 4'h5,  6, 32'hFFFF_FFFF, 7, 32'h0,          1'b0, 8};
        tbl[6] = '{1'b0, 32'h3000_0020, 32'h0,         4'h2,  1, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b0, 3};
        tbl[7] = '{1'b1, 32'h3000_0024, 32'h7777_8888, 4'h8,  7, 32'hFFFF_FFFF, 8, 32'h0,          1'b0, 9};

        repeat (2) @(negedge wb_clk_i);
        chk("reset ctrl", {26'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err, busy}, 32'd0);
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset bus", wbm_adr_o | wbm_dat_o | {28'd0, wbm_sel_o} | rsp_dat, 32'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // backpressure with cmd_valid held high; second command must enter one edge after handshake
        slv_wait = 0; slv_rdata = 32'h5555_AAAA;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_adr = 32'h3000_0044;
        @(negedge wb_clk_i);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp hold%0d", i), {rsp_valid, cmd_ready, rsp_dat[29:0]}, {2'b10, 30'h1555_AAAA});
            @(negedge wb_clk_i);
        end
        chk("bp rsp_dat", rsp_dat, 32'h5555_AAAA);
        slv_rdata = 32'h6666_9999;
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        chk("bp after_hs", {29'd0, rsp_valid, cmd_ready, wbm_cyc_o}, 32'b010);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        chk("bp second accept", {wbm_cyc_o, wbm_adr_o[30:0]}, {1'b1, 31'h3000_0044});
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin @(negedge wb_clk_i); k++; end
        chk("bp second rsp", rsp_dat, 32'h6666_9999);
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;

        // reset in the second stb cycle of a 3-wait-state read
        slv_wait = 3; slv_rdata = 32'h0123_4567;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0050;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
        @(negedge wb_clk_i);
        chk("rst pre stb", 32'(wbm_stb_o), 32'd1);
        wb_rst_i = 1'b1;
        #1;
        chk("rst async", {27'd0, wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err, busy}, 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk_i);
            chk($sformatf("rst idle%0d", i), {29'd0, cmd_ready, rsp_valid, wbm_stb_o}, 32'b100);
        end
        run_vec('{1'b0, 32'h3000_0058, 32'h0, 4'hC, 2, 32'h89AB_CDEF, 3, 32'h89AB_CDEF, 1'b0, 4}, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/wb_host_master.md
# wb_host_master

Wishbone classic initiator that drives the user project's `wbs_*` slave port, so the user macro can be exercised by an on-chip sequencer or a synthesizable bench without the management SoC. It accepts one command at a time over a valid/ready request channel and runs a single-beat Wishbone read or write. It returns read data or a timeout error over a valid/ready response channel. It runs in the `wb_clk_i` domain, alongside `user_proj_example`.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum number of cycles `stb` stays high without `ack` before the cycle is aborted (legal range 1..65535).
- `ERR_DATA`, 32'hDEAD_BEEF: value returned on `rsp_dat` for a timed-out read.
- `wb_clk_i` in 1: the only clock; all state is clocked on its rising edge.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when this and `cmd_valid` are both high at a rising edge.
- `cmd_we` in 1: 1 selects write, 0 selects read.
- `cmd_adr` in 32: byte address.
- `cmd_dat` in 32: write data.
- `cmd_sel` in 4: byte selects.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when this and `rsp_valid` are both high at a rising edge.
- `rsp_dat` out 32: read data; 0 for writes; `ERR_DATA` for a timed-out read.
- `rsp_err` out 1: high when the cycle timed out.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1: bus control, connected to `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`.
- `wbm_adr_o`, `wbm_dat_o` out 32 each; `wbm_sel_o` out 4: bus address, write data and byte selects.
- `wbm_dat_i` in 32: read data from the slave.
- `wbm_ack_i` in 1: cycle acknowledge from the slave.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, BUS, RESP. Reset state is IDLE.
- Reset values: all outputs are 0, except `cmd_ready`, which is 1 because it is decoded from IDLE.
- **IDLE**
  - `cmd_ready` = 1.
  - On command acceptance, register `we`, `adr`, `dat` and `sel` onto the `wbm_*` outputs, set `cyc` and `stb` to 1, clear the timeout counter, and go to BUS.
- **BUS**
  - `cmd_ready` = 0.
  - `wbm_adr_o`, `wbm_dat_o`, `wbm_sel_o` and `wbm_we_o` stay stable until `cyc` falls.
  - When `wbm_ack_i` is sampled high:
    - Read: capture `wbm_dat_i` into `rsp_dat`.
    - Write: set `rsp_dat` to 0.
    - Set `rsp_err` to 0, drop `cyc` and `stb` on the same edge, and go to RESP.
  - When `wbm_ack_i` is sampled low: increment the counter. If the counter equals `TIMEOUT_CYCLES-1` at that edge:
    - Drop `cyc` and `stb`.
    - Set `rsp_err` to 1.
    - Set `rsp_dat` to `ERR_DATA` for a read, or 0 for a write.
    - Go to RESP.
  - If `ack` and the timeout condition occur on the same edge, `ack` wins and `rsp_err` = 0.
- **RESP**
  - `rsp_valid` = 1; `rsp_dat` and `rsp_err` are held.
  - On handshake, drop `rsp_valid` and go to IDLE.
  - `cmd_ready` stays 0 until the state is back in IDLE; the block does no command buffering.
- `wbm_ack_i` is ignored in IDLE and RESP.
- `wbm_we_o` and `wbm_sel_o` keep their last values while `cyc` = 0. `wbm_dat_o` is don't-care for reads.
- Counter width is 16 bits. It counts only in BUS and saturates safely; it cannot wrap before the timeout fires.
- Reset asserted mid-operation:
  - `cyc`, `stb`, `rsp_valid` and `rsp_err` go low immediately, asynchronously.
  - Any in-flight command or pending response is discarded.

## Timing
- Command accepted at edge N: `cyc` and `stb` are high from N+1.
- Zero-wait slave (`ack` high in the first `stb` cycle): `ack` is sampled at N+2; `rsp_valid` is high from N+2.
  - With `rsp_ready` held at 1, the next command can be accepted at edge N+3.
  - Minimum issue interval is 3 cycles.
- Slave with W wait states: `stb` is high for W+1 cycles; `rsp_valid` rises at N+2+W.
- Timeout: `stb` is high for exactly `TIMEOUT_CYCLES` cycles; `rsp_valid` rises at N+1+`TIMEOUT_CYCLES`.
- All outputs are registered or decoded from state only; there is no combinational path from an input to an output.

## Structure
- Package `wb_host_pkg` holds:
  - the `state_t` enum (IDLE/BUS/RESP);
  - `WB_AW` = 32, `WB_DW` = 32, `WB_SW` = 4;
  - the default `ERR_DATA`.
- One sub-module, `wb_timeout_ctr`:
  - ports: `clear`, `enable`, `expired` (expired means count == `TIMEOUT_CYCLES-1` while enable is high);
  - takes the same clock and asynchronous reset as the top.

## Test plan
- Write `adr` = 0x3000_0004, `dat` = 0xA5A5_1234, `sel` = 0xF to a zero-wait slave. Require:
  - `cyc`/`stb`/`we` high for exactly 1 cycle with those values;
  - response `rsp_err` = 0, `rsp_dat` = 0.
- Read `adr` = 0x3000_0008 from a slave with 3 wait states returning 0xCAFE_F00D. Require:
  - `stb` high for 4 cycles;
  - `rsp_dat` = 0xCAFE_F00D, `rsp_err` = 0;
  - `rsp_valid` at N+5.
- `TIMEOUT_CYCLES` = 8, slave never acks, read. Require:
  - `stb` high for exactly 8 cycles;
  - `rsp_err` = 1, `rsp_dat` = 0xDEAD_BEEF.
  - Repeat as a write and require `rsp_dat` = 0.
- `TIMEOUT_CYCLES` = 8, `ack` arrives in the 8th `stb` cycle. Require `rsp_err` = 0 and the returned data is correct.
- Backpressure: `rsp_ready` held at 0 for 10 cycles with `cmd_valid` held at 1. Require:
  - `rsp_valid` and `rsp_dat` stable and `cmd_ready` = 0 throughout;
  - the second command is accepted exactly one edge after the response handshake.
- Assert `wb_rst_i` in the second `stb` cycle of a wait-state read. Require:
  - `cyc`/`stb` low before the next edge, with no response issued;
  - after release, `cmd_ready` = 1 and a fresh read completes normally.
